// File: rtl/qar_dmem_responder.sv
// Word-addressed data-memory responder for the qar_core load/store port.
// Each request is held for WAIT_STATES stall cycles, then answered with a one-cycle mem_ready_o.
module qar_dmem_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_req_i,
  input  logic [31:0]          mem_addr_i,
  input  logic                 mem_we_i,
  input  logic [31:0]          mem_wdata_i,
  output logic                 mem_ready_o,
  output logic [31:0]          mem_rdata_o,
  output logic                 mem_err_o,
  output logic [CNT_WIDTH-1:0] store_count_o,
  output logic                 busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait_states
    $error("qar_dmem_responder: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  store_count_q;
  logic [31:0]           mem [DEPTH];

  logic                  err;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  commit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign err      = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_WIDTH+2] != '0);
  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  // A store commits on the edge that leaves RESP; a reset on that edge discards it.
  assign commit   = !rst_i && (state_q == S_RESP) && we_q && !err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      store_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (commit) store_count_q <= sat_inc(store_count_q);
    end
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk_i) begin
    if (commit) mem[word_idx] <= wdata_q;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          addr_d     = mem_addr_i;
          we_d       = mem_we_i;
          wdata_d    = mem_wdata_i;
          wait_cnt_d = 4'(WAIT_STATES);
          state_d    = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready_o = (state_q == S_RESP);
    mem_err_o   = (state_q == S_RESP) && err;
    busy_o      = (state_q != S_IDLE);
    mem_rdata_o = '0;
    if ((state_q == S_RESP) && !we_q && !err) mem_rdata_o = mem[word_idx];
  end

  assign store_count_o = store_count_q;

endmodule

// File: tb/tb_qar_dmem_responder.sv
// Directed bench for qar_dmem_responder: three instances cover WAIT_STATES = 1, 0 and 3,
// the zero-wait one also uses a 2-bit store counter so saturation is reachable.
module tb_qar_dmem_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  req = 3'b000;
  logic [31:0] t_addr = '0;
  logic        t_we = 1'b0;
  logic [31:0] t_wdata = '0;
  logic [2:0]  rdy, err, busy;
  logic [31:0] rdata [3];
  logic [15:0] cnt_a, cnt_c;
  logic [1:0]  cnt_b;

  int npass = 0;
  int nchk  = 0;
  int nfail = 0;

  logic [31:0] model [64];
  int          exp_cnt;

  always #5 clk = ~clk;

  qar_dmem_responder #(.ADDR_WIDTH(6), .WAIT_STATES(1), .CNT_WIDTH(16)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .mem_req_i(req[0]), .mem_addr_i(t_addr), .mem_we_i(t_we),
    .mem_wdata_i(t_wdata), .mem_ready_o(rdy[0]), .mem_rdata_o(rdata[0]), .mem_err_o(err[0]),
    .store_count_o(cnt_a), .busy_o(busy[0]));

  qar_dmem_responder #(.ADDR_WIDTH(6), .WAIT_STATES(0), .CNT_WIDTH(2)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .mem_req_i(req[1]), .mem_addr_i(t_addr), .mem_we_i(t_we),
    .mem_wdata_i(t_wdata), .mem_ready_o(rdy[1]), .mem_rdata_o(rdata[1]), .mem_err_o(err[1]),
    .store_count_o(cnt_b), .busy_o(busy[1]));

  qar_dmem_responder #(.ADDR_WIDTH(6), .WAIT_STATES(3), .CNT_WIDTH(16)) u_c (
    .clk_i(clk), .rst_i(rst[2]), .mem_req_i(req[2]), .mem_addr_i(t_addr), .mem_we_i(t_we),
    .mem_wdata_i(t_wdata), .mem_ready_o(rdy[2]), .mem_rdata_o(rdata[2]), .mem_err_o(err[2]),
    .store_count_o(cnt_c), .busy_o(busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raises req on instance k, counts rising edges until mem_ready, and records busy after each edge.
  // Returns sampled just after the edge that entered RESP; req is dropped before RESP ends.
  task automatic do_op(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat,
                       output logic [7:0] bh);
    @(negedge clk);
    t_addr  = a;
    t_we    = w;
    t_wdata = d;
    req[k]  = 1'b1;
    lat = 0;
    bh  = '0;
    rd  = '0;
    e   = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      bh = {bh[6:0], busy[k]};
      if (rdy[k] === 1'b1) break;
      if (lat >= 40) begin
        chk("ready_timeout", 32'(lat), 32'd0);
        break;
      end
    end
    rd = rdata[k];
    e  = err[k];
    req[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [7:0]  bh;
    int          any_rdy;

    u_a.mem[0]  = 32'h0BAD_F00D;
    u_a.mem[3]  = 32'hDEAD_BEEF;
    u_b.mem[5]  = 32'h1111_1111;
    u_b.mem[6]  = 32'h2222_2222;
    u_c.mem[2]  = 32'hA5A5_A5A5;
    u_c.mem[9]  = 32'h0000_9999;

    repeat (3) @(posedge clk);
    #1;
    rst = 3'b000;
    idle(1);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);

    // T1: basic load, WAIT_STATES=1
    do_op(0, 1'b0, 32'h0000_000C, 32'd0, rd, e, lat, bh);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_rdata", rd, 32'hDEAD_BEEF);
    chk("t1_err", 32'(e), 32'd0);
    chk("t1_busy_hist", 32'(bh[1:0]), 32'b11);
    idle(1);
    chk("t1_idle_ready", 32'(rdy[0]), 32'd0);
    chk("t1_idle_busy", 32'(busy[0]), 32'd0);

    // T2: store then load back (read-after-write)
    do_op(0, 1'b1, 32'h0000_0044, 32'h0000_0123, rd, e, lat, bh);
    chk("t2_st_err", 32'(e), 32'd0);
    chk("t2_st_rdata", rd, 32'd0);
    idle(1);
    chk("t2_count", 32'(cnt_a), 32'd1);
    do_op(0, 1'b0, 32'h0000_0044, 32'd0, rd, e, lat, bh);
    chk("t2_ld_rdata", rd, 32'h0000_0123);
    idle(1);

    // T3: misaligned load and out-of-range store
    do_op(0, 1'b0, 32'h0000_0102, 32'd0, rd, e, lat, bh);
    chk("t3_mis_err", 32'(e), 32'd1);
    chk("t3_mis_rdata", rd, 32'd0);
    chk("t3_mis_latency", 32'(lat), 32'd2);
    idle(1);
    do_op(0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, rd, e, lat, bh);
    chk("t3_oor_err", 32'(e), 32'd1);
    chk("t3_oor_rdata", rd, 32'd0);
    idle(1);
    chk("t3_count", 32'(cnt_a), 32'd1);
    chk("t3_mem0", u_a.mem[0], 32'h0BAD_F00D);
    do_op(0, 1'b0, 32'h0000_0000, 32'd0, rd, e, lat, bh);
    chk("t3_mem0_load", rd, 32'h0BAD_F00D);
    idle(1);

    // T4: zero wait states, back-to-back loads
    do_op(1, 1'b0, 32'h0000_0014, 32'd0, rd, e, lat, bh);
    chk("t4_lat0", 32'(lat), 32'd1);
    chk("t4_rdata0", rd, 32'h1111_1111);
    chk("t4_busy0", 32'(bh[0]), 32'd1);
    do_op(1, 1'b0, 32'h0000_0018, 32'd0, rd, e, lat, bh);
    chk("t4_lat1_bubble", 32'(lat), 32'd2);
    chk("t4_busy1_hist", 32'(bh[1:0]), 32'b01);
    chk("t4_rdata1", rd, 32'h2222_2222);
    idle(1);

    // T4b: 2-bit store counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      do_op(1, 1'b1, 32'(i * 4 + 32), 32'(i), rd, e, lat, bh);
      idle(1);
      if (i == 1) chk("t4_cnt2", 32'(cnt_b), 32'd2);
    end
    chk("t4_cnt_sat", 32'(cnt_b), 32'd3);

    // WAIT_STATES=3 normal load latency
    do_op(2, 1'b0, 32'h0000_0024, 32'd0, rd, e, lat, bh);
    chk("ws3_latency", 32'(lat), 32'd4);
    chk("ws3_rdata", rd, 32'h0000_9999);
    idle(1);

    // T5: reset during second WAIT cycle discards the store
    @(negedge clk);
    t_addr = 32'h0000_0008;
    t_we = 1'b1;
    t_wdata = 32'h0000_0055;
    req[2] = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_busy_wait", 32'(busy[2]), 32'd1);
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    req[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    chk("t5_busy_after_rst", 32'(busy[2]), 32'd0);
    any_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rdy[2] === 1'b1) any_rdy++;
    end
    chk("t5_no_ready", 32'(any_rdy), 32'd0);
    chk("t5_mem2", u_c.mem[2], 32'hA5A5_A5A5);
    chk("t5_count", 32'(cnt_c), 32'd0);
    chk("t5_idle", 32'(busy[2]), 32'd0);

    // T6: random aligned in-range ops against a bench model
    for (int i = 0; i < 64; i++) begin
      model[i] = 32'h5000_0000 + 32'(i);
      u_a.mem[i] = model[i];
    end
    exp_cnt = 1;
    for (int i = 0; i < 200; i++) begin
      int          idx;
      logic        w;
      logic [31:0] d;
      idx = int'($urandom_range(0, 63));
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      do_op(0, w, 32'(idx) << 2, d, rd, e, lat, bh);
      if (!w) chk("t6_rdata", rd, model[idx]);
      else begin
        model[idx] = d;
        exp_cnt++;
      end
      idle(1);
    end
    chk("t6_count", 32'(cnt_a), 32'(exp_cnt));

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
